// File: rtl/mem_port_arbiter_pkg.sv
// mem_port_arbiter_pkg: state/grant encodings and counter sizing shared by mem_port_arbiter and its grant unit
package mem_port_arbiter_pkg;
   typedef enum logic [1:0] {IDLE, BUS, BACKOFF, RESP} state_t;
   typedef enum logic {GNT_A, GNT_B} gnt_t;
   localparam int RETRY_MAX_DEF = 7;
   localparam int STARVE_LIMIT_DEF = 4;
   localparam int TIMEOUT_CYCLES_DEF = 255;
   function automatic int cnt_w(input int n);
      return n < 2 ? 1 : $clog2(n + 1);
   endfunction
   localparam int RETRY_W = cnt_w(RETRY_MAX_DEF);
   localparam int STARVE_W = cnt_w(STARVE_LIMIT_DEF);
   localparam int TIMEOUT_W = cnt_w(TIMEOUT_CYCLES_DEF);
endpackage

// File: rtl/mem_port_arbiter_grant.sv
// mem_port_arbiter_grant: fixed priority to B with a starvation counter that forces A after STARVE_LIMIT B wins
module mem_port_arbiter_grant
   import mem_port_arbiter_pkg::*;
#(
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic a_valid,
   input  logic b_valid,
   input  logic take,
   output gnt_t gnt
);
   localparam int SW = cnt_w(STARVE_LIMIT);
   logic [SW-1:0] starve_cnt;
   logic a_forced;
   assign a_forced = a_valid && starve_cnt == SW'(STARVE_LIMIT);
   assign gnt = (a_forced || !b_valid) ? GNT_A : GNT_B;
   always_ff @(posedge clk)
      if (rst)
         starve_cnt <= '0;
      else if (take && (a_valid || b_valid))
         starve_cnt <= gnt == GNT_A ? '0 :
                       (a_valid && starve_cnt != SW'(STARVE_LIMIT)) ? starve_cnt + 1'b1 : starve_cnt;
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one Wishbone classic master between fetch port A and data port B
// Define MEM_PORT_ARBITER_TIMEOUT_EN to add a watchdog that errors out a BUS phase after TIMEOUT_CYCLES.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH = 128,
   parameter int RETRY_MAX = RETRY_MAX_DEF,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   localparam int SEL_WIDTH = DATA_WIDTH / 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  a_valid,
   input  logic [31:0]           a_addr,
   output logic                  a_ready,
   output logic [DATA_WIDTH-1:0] a_rdata,
   output logic                  a_err,
   input  logic                  b_valid,
   input  logic [31:0]           b_addr,
   input  logic [DATA_WIDTH-1:0] b_wdata,
   input  logic [SEL_WIDTH-1:0]  b_sel,
   input  logic                  b_we,
   output logic                  b_ready,
   output logic [DATA_WIDTH-1:0] b_rdata,
   output logic                  b_err,
   output logic [31:0]           wb_adr_o,
   output logic [DATA_WIDTH-1:0] wb_dat_o,
   input  logic [DATA_WIDTH-1:0] wb_dat_i,
   output logic                  wb_we_o,
   output logic [SEL_WIDTH-1:0]  wb_sel_o,
   output logic                  wb_stb_o,
   output logic                  wb_cyc_o,
   input  logic                  wb_ack_i,
   input  logic                  wb_err_i,
   input  logic                  wb_rty_i
);
   localparam int RW = cnt_w(RETRY_MAX);
   state_t state;
   gnt_t gnt, owner;
   logic [RW-1:0] retry_cnt;
   logic timeout, done, fail, rd_ok;
   mem_port_arbiter_grant #(.STARVE_LIMIT(STARVE_LIMIT)) u_grant (
      .clk(clk),
      .rst(rst),
      .a_valid(a_valid),
      .b_valid(b_valid),
      .take(state == IDLE),
      .gnt(gnt)
   );
`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
   localparam int TW = cnt_w(TIMEOUT_CYCLES);
   logic [TW-1:0] wd_cnt;
   always_ff @(posedge clk)
      wd_cnt <= (rst || state != BUS) ? '0 : wd_cnt + 1'b1;
   assign timeout = state == BUS && wd_cnt == TW'(TIMEOUT_CYCLES - 1);
`else
   assign timeout = 1'b0;
`endif
   // err outranks ack; exhausted retries and watchdog expiry also complete as errors
   assign done = wb_err_i || wb_ack_i || timeout || (wb_rty_i && retry_cnt == RW'(RETRY_MAX));
   assign fail = wb_err_i || !wb_ack_i;
   assign rd_ok = !fail && !wb_we_o;
   always_ff @(posedge clk)
      if (rst) begin
         state <= IDLE;
         owner <= GNT_A;
         retry_cnt <= '0;
         wb_adr_o <= '0;
         wb_dat_o <= '0;
         wb_we_o <= 1'b0;
         wb_sel_o <= '0;
         wb_stb_o <= 1'b0;
         wb_cyc_o <= 1'b0;
         a_ready <= 1'b0;
         a_err <= 1'b0;
         a_rdata <= '0;
         b_ready <= 1'b0;
         b_err <= 1'b0;
         b_rdata <= '0;
      end else
         case (state)
            IDLE:
               if (a_valid || b_valid) begin
                  owner <= gnt;
                  wb_adr_o <= gnt == GNT_A ? a_addr : b_addr;
                  wb_dat_o <= gnt == GNT_A ? '0 : b_wdata;
                  wb_we_o <= gnt == GNT_B && b_we;
                  wb_sel_o <= gnt == GNT_A ? '1 : b_sel;
                  wb_stb_o <= 1'b1;
                  wb_cyc_o <= 1'b1;
                  retry_cnt <= '0;
                  state <= BUS;
               end
            BUS:
               if (done) begin
                  wb_stb_o <= 1'b0;
                  wb_cyc_o <= 1'b0;
                  a_ready <= owner == GNT_A;
                  b_ready <= owner == GNT_B;
                  a_err <= owner == GNT_A && fail;
                  b_err <= owner == GNT_B && fail;
                  a_rdata <= (owner == GNT_A && rd_ok) ? wb_dat_i : '0;
                  b_rdata <= (owner == GNT_B && rd_ok) ? wb_dat_i : '0;
                  state <= RESP;
               end else if (wb_rty_i) begin
                  wb_stb_o <= 1'b0;
                  wb_cyc_o <= 1'b0;
                  retry_cnt <= retry_cnt + 1'b1;
                  state <= BACKOFF;
               end
            BACKOFF: begin
               wb_stb_o <= 1'b1;
               wb_cyc_o <= 1'b1;
               state <= BUS;
            end
            RESP: begin
               a_ready <= 1'b0;
               a_err <= 1'b0;
               a_rdata <= '0;
               b_ready <= 1'b0;
               b_err <= 1'b0;
               b_rdata <= '0;
               state <= IDLE;
            end
         endcase
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench for mem_port_arbiter (timeout case runs with MEM_PORT_ARBITER_TIMEOUT_EN)
module tb_mem_port_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   logic a_valid = 1'b0, b_valid = 1'b0, b_we = 1'b0;
   logic [31:0] a_addr = '0, b_addr = '0;
   logic [127:0] b_wdata = '0, wb_dat_i = '0;
   logic [15:0] b_sel = '0;
   logic wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_rty_i = 1'b0;
   logic a_ready, a_err, b_ready, b_err, wb_we_o, wb_stb_o, wb_cyc_o;
   logic [127:0] a_rdata, b_rdata, wb_dat_o;
   logic [31:0] wb_adr_o;
   logic [15:0] wb_sel_o;
   int n_tests = 0, n_fail = 0;
   localparam logic [127:0] PAT = 128'h0123_4567_89AB_CDEF_0000_0000_DEAD_BEEF;
   localparam logic [127:0] WD = 128'hA5A5_0000_1111_2222_3333_4444_5555_6666;

   mem_port_arbiter #(.TIMEOUT_CYCLES(16)) dut (
      .clk(clk), .rst(rst),
      .a_valid(a_valid), .a_addr(a_addr), .a_ready(a_ready), .a_rdata(a_rdata), .a_err(a_err),
      .b_valid(b_valid), .b_addr(b_addr), .b_wdata(b_wdata), .b_sel(b_sel), .b_we(b_we),
      .b_ready(b_ready), .b_rdata(b_rdata), .b_err(b_err),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_we_o(wb_we_o),
      .wb_sel_o(wb_sel_o), .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o),
      .wb_ack_i(wb_ack_i), .wb_err_i(wb_err_i), .wb_rty_i(wb_rty_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic wait_stb(input string tag);
      int n = 0;
      while (!wb_stb_o && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_stb"}, wb_stb_o, 1'b1);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_ctl"}, {wb_cyc_o, wb_stb_o, wb_we_o, a_ready, b_ready, a_err, b_err}, '0);
      chk({tag, "_bus"}, {wb_adr_o, wb_sel_o}, '0);
      chk({tag, "_rd"}, a_rdata | b_rdata | wb_dat_o, '0);
   endtask

   task automatic serve(input logic exp_b, input string tag);
      wait_stb(tag);
      chk({tag, "_we"}, wb_we_o, exp_b);
      chk({tag, "_sel"}, wb_sel_o, exp_b ? 16'h000F : 16'hFFFF);
      wb_ack_i = 1'b1;
      wb_dat_i = PAT;
      @(negedge clk);
      wb_ack_i = 1'b0;
      chk({tag, "_rdy"}, {a_ready, b_ready}, exp_b ? 2'b01 : 2'b10);
      chk({tag, "_data"}, exp_b ? b_rdata : a_rdata, exp_b ? '0 : PAT);
   endtask

   initial begin
      int gaps;
      logic [5:0] order = 6'b101111;
      @(negedge clk);
      @(negedge clk);
      chk_idle("reset");
      rst = 1'b0;
      a_valid = 1'b1;
      a_addr = 32'h100;
      @(negedge clk);
      chk("a_rd_stb_c1", wb_stb_o, 1'b1);
      chk("a_rd_adr", wb_adr_o, 32'h100);
      chk("a_rd_we_sel", {wb_we_o, wb_sel_o}, {1'b0, 16'hFFFF});
      wb_ack_i = 1'b1;
      wb_dat_i = PAT;
      @(negedge clk);
      wb_ack_i = 1'b0;
      a_valid = 1'b0;
      chk("a_rd_ready_c2", {a_ready, a_err, b_ready}, 3'b100);
      chk("a_rd_data", a_rdata, PAT);
      @(negedge clk);
      chk("a_rd_pulse", {a_ready, wb_cyc_o}, 2'b00);

      a_valid = 1'b1;
      a_addr = 32'h200;
      b_valid = 1'b1;
      b_we = 1'b1;
      b_sel = 16'h000F;
      b_addr = 32'h3000;
      b_wdata = WD;
      for (int i = 0; i < 6; i++) begin
         if (order[i]) begin
            wait_stb($sformatf("prio%0d", i));
            chk($sformatf("prio%0d_wdat", i), wb_dat_o, WD);
         end
         serve(order[i], $sformatf("prio%0d", i));
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
      b_we = 1'b0;
      b_addr = 32'h2000;
      b_sel = 16'hFFFF;
      @(negedge clk);

      b_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         wait_stb($sformatf("rty3_%0d", i));
         chk($sformatf("rty3_adr%0d", i), wb_adr_o, 32'h2000);
         if (i < 3) begin
            wb_rty_i = 1'b1;
            @(negedge clk);
            wb_rty_i = 1'b0;
            chk($sformatf("rty3_gap%0d", i), wb_cyc_o, 1'b0);
            @(negedge clk);
            chk($sformatf("rty3_back%0d", i), wb_stb_o, 1'b1);
         end else begin
            wb_ack_i = 1'b1;
            wb_dat_i = PAT;
            @(negedge clk);
            wb_ack_i = 1'b0;
            b_valid = 1'b0;
            chk("rty3_ready", {b_ready, b_err, a_ready}, 3'b100);
            chk("rty3_data", b_rdata, PAT);
         end
      end
      @(negedge clk);
      chk("rty3_once", b_ready, 1'b0);

      b_valid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wait_stb($sformatf("rty8_%0d", i));
         wb_rty_i = 1'b1;
         @(negedge clk);
         wb_rty_i = 1'b0;
         chk($sformatf("rty8_gap%0d", i), wb_cyc_o, 1'b0);
         if (i == 7) b_valid = 1'b0;
      end
      chk("rty8_fail", {b_ready, b_err}, 2'b11);
      gaps = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         gaps += int'(wb_stb_o);
      end
      chk("rty8_no9th", gaps, 0);

      a_valid = 1'b1;
      a_addr = 32'h400;
      wait_stb("ackerr");
      wb_ack_i = 1'b1;
      wb_err_i = 1'b1;
      @(negedge clk);
      wb_ack_i = 1'b0;
      wb_err_i = 1'b0;
      a_valid = 1'b0;
      chk("ackerr_err", {a_ready, a_err, b_ready}, 3'b110);

      @(negedge clk);
      a_valid = 1'b1;
      wait_stb("rstbus");
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      a_valid = 1'b0;
      chk_idle("rstbus");
      gaps = 0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         gaps += int'(a_ready | b_ready | wb_cyc_o);
      end
      chk("rstbus_quiet", gaps, 0);

`ifdef MEM_PORT_ARBITER_TIMEOUT_EN
      a_valid = 1'b1;
      wait_stb("tmo");
      gaps = 0;
      while (wb_stb_o && gaps < 40) begin
         gaps++;
         @(negedge clk);
      end
      a_valid = 1'b0;
      chk("tmo_cycles", gaps, 16);
      chk("tmo_err", {a_ready, a_err, wb_cyc_o}, 3'b110);
`endif
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one Wishbone classic master between two CPU requesters:
  - port A, instruction fetch, read-only;
  - port B, data load/store.
- Sits between the pipeline memory ports and the external bus, at 128-bit line width.
- Fixed priority to B, with a starvation guard for A.
- Handles bus retry and error, and returns the response to exactly one requester.

Parameters:
DATA_WIDTH, 128, bus/line data width in bits.
SEL_WIDTH, DATA_WIDTH/8, byte-select width (derived, not overridable).
RETRY_MAX, 7, bus retries allowed per transfer before failing with error.
STARVE_LIMIT, 4, consecutive B grants while A waits before A is forced to win.
TIMEOUT_CYCLES, 255, bus watchdog limit (used only with the optional feature).

Ports:
clk  in  1  system clock; all logic on the rising edge.
rst  in  1  synchronous, active-high reset.
a_valid  in  1  fetch request pending; held with a_addr stable until the a_ready pulse.
a_addr  in  32  fetch address.
a_ready  out  1  one-cycle completion pulse for A.
a_rdata  out  DATA_WIDTH  read data; valid while a_ready=1.
a_err  out  1  qualifies a_ready: transfer failed.
b_valid  in  1  data request pending; held with its fields stable until b_ready.
b_addr  in  32  data address.
b_wdata  in  DATA_WIDTH  store data.
b_sel  in  SEL_WIDTH  byte enables.
b_we  in  1  1 = store.
b_ready  out  1  one-cycle completion pulse for B.
b_rdata  out  DATA_WIDTH  load data; valid while b_ready=1.
b_err  out  1  qualifies b_ready.
wb_adr_o  out  32  bus address.
wb_dat_o  out  DATA_WIDTH  bus write data.
wb_dat_i  in  DATA_WIDTH  bus read data.
wb_we_o  out  1  bus write enable.
wb_sel_o  out  SEL_WIDTH  bus byte select.
wb_stb_o  out  1  strobe.
wb_cyc_o  out  1  cycle.
wb_ack_i  in  1  normal termination.
wb_err_i  in  1  error termination.
wb_rty_i  in  1  retry termination.

Behaviour:
- All outputs are registered.
- Reset values:
  - all wb_* outputs 0;
  - a_ready, b_ready, a_err, b_err all 0;
  - rdata 0;
  - state IDLE;
  - retry and starve counters 0.
- States: IDLE, BUS, BACKOFF, RESP.
- IDLE (arbitration):
  - If starve_cnt==STARVE_LIMIT and a_valid: grant A.
  - Else if b_valid: grant B; if a_valid, starve_cnt++ (saturating).
  - Else if a_valid: grant A.
  - Any A grant clears starve_cnt.
  - On a grant: latch addr/wdata/sel/we (A forces we=0, sel all-ones), clear retry_cnt, go to BUS.
- BUS:
  - cyc=stb=1 with the latched fields.
  - Termination priority when several are sampled in the same cycle: err > ack > rty.
  - ack: latch wb_dat_i, go to RESP with err=0.
  - err: go to RESP with err=1.
  - rty: if retry_cnt==RETRY_MAX, go to RESP with err=1; else retry_cnt++ and go to BACKOFF.
- BACKOFF: cyc=stb=0 for exactly one cycle, then back to BUS with the same fields.
- RESP:
  - The granted port's ready=1 (and err if set) for exactly one cycle; rdata valid in that cycle. The other port's outputs stay 0.
  - Next state is IDLE.
- Minimum latency: valid sampled at cycle 0, stb at cycle 1, ack sampled at cycle 1, ready at cycle 2. Next grant possible from cycle 3.
- The requester deasserts valid, or presents a new request, in the cycle after ready. Back-to-back requests cost one IDLE cycle.
- valid asserted while another port owns the bus: held pending, no effect.
- Store: rdata=0 at completion.
- rst mid-transfer: cyc/stb drop on the next edge and no ready pulse is issued. Requesters must re-issue.

Optional Feature:
- Macro MEM_PORT_ARBITER_TIMEOUT_EN.
- Defined:
  - A watchdog counts cycles in BUS without termination.
  - When it reaches TIMEOUT_CYCLES, drop cyc/stb and go to RESP with err=1.
  - The watchdog clears on entry to BUS and in BACKOFF.
- Undefined: no watchdog logic; BUS waits indefinitely. TIMEOUT_CYCLES is ignored.

Decomposition:
- Package mem_port_arbiter_pkg holds:
  - the state encoding (IDLE/BUS/BACKOFF/RESP);
  - grant encoding (GNT_A, GNT_B);
  - counter width constants derived from RETRY_MAX, STARVE_LIMIT and TIMEOUT_CYCLES.
- One sub-module, mem_port_arbiter_grant: priority selection plus the starvation counter. Its inputs are a_valid, b_valid and grant-taken; its output is the grant.

Test Plan:
- A-only read at 0x100, ack on the first stb cycle with 0x…DEADBEEF → stb at cycle 1, a_ready=1 at cycle 2 with that data, a_err=0, wb_we_o=0, wb_sel_o=0xFFFF.
- A and B both valid every cycle (B store, sel=0x000F) → grant order B,B,B,B,A,B… (A on the 5th grant with STARVE_LIMIT=4); B's store shows we=1 and sel=0x000F on the bus.
- B read gets rty three times then ack → three one-cycle cyc=0 gaps; the address is identical on every attempt; b_ready once, b_err=0.
- B read gets rty 8 times with RETRY_MAX=7 → b_ready with b_err=1 after the 8th rty; no 9th attempt.
- ack and err asserted in the same cycle → err wins, a_err=1. Separately, rst during BUS → cyc=0 on the next edge, no ready pulse, all outputs at reset values.
- With MEM_PORT_ARBITER_TIMEOUT_EN and TIMEOUT_CYCLES=16, a bus that never terminates → cyc drops after 16 BUS cycles, then a_ready with a_err=1.
